// File: rtl/instr_fifo_assembler.sv
// instr_fifo_assembler: assembles BUS_WIDTH beats into instructions, queues them in a FIFO
// and presents the head entry split into fields.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous clear of FIFO and partial assembly
//   in_valid/in_ready/in_data       beat input handshake and payload (beat 0 = LSBs)
//   out_valid/out_ready             head instruction handshake (first-word-fall-through)
//   out_buff_addr/out_acc_addr/out_length/out_opcode   head fields, zero when empty
//   fifo_count     number of stored instructions
//   beat_idx       index of the next expected beat
module instr_fifo_assembler #(
    parameter int BUFF_ADDR_WIDTH = 24,
    parameter int ACC_ADDR_WIDTH  = 16,
    parameter int LENGTH_WIDTH    = 32,
    parameter int OPCODE_WIDTH    = 8,
    parameter int BUS_WIDTH       = 32,
    parameter int FIFO_DEPTH      = 16,
    localparam int INSTR_WIDTH = BUFF_ADDR_WIDTH + ACC_ADDR_WIDTH + LENGTH_WIDTH + OPCODE_WIDTH,
    localparam int NUM_BEATS   = (INSTR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1,
    localparam int BI_W        = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BUS_WIDTH-1:0]       in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BUFF_ADDR_WIDTH-1:0] out_buff_addr,
    output logic [ACC_ADDR_WIDTH-1:0]  out_acc_addr,
    output logic [LENGTH_WIDTH-1:0]    out_length,
    output logic [OPCODE_WIDTH-1:0]    out_opcode,
    output logic [CNT_W-1:0]           fifo_count,
    output logic [BI_W-1:0]            beat_idx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [INSTR_WIDTH-1:0] BEAT_MASK = INSTR_WIDTH'({BUS_WIDTH{1'b1}});

    logic [INSTR_WIDTH-1:0] asm_q, asm_next, head;
    logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [31:0]            shamt;
    logic                   last_beat, accept, push, pop;

    assign last_beat = beat_idx == BI_W'(NUM_BEATS - 1);
    // Only the final beat needs FIFO space; earlier beats land in the assembly register.
    assign in_ready  = !(fifo_count == CNT_W'(FIFO_DEPTH) && last_beat);
    assign accept    = in_valid && in_ready && !flush;
    assign push      = accept && last_beat;
    assign out_valid = fifo_count != '0;
    assign pop       = out_valid && out_ready && !flush;

    // Bits shifted past INSTR_WIDTH drop off, clipping the last beat.
    assign shamt    = 32'(beat_idx) * BUS_WIDTH;
    assign asm_next = (asm_q & ~(BEAT_MASK << shamt)) | (INSTR_WIDTH'(in_data) << shamt);

    assign head          = mem[rd_ptr];
    assign out_opcode    = out_valid ? head[OPCODE_WIDTH-1:0] : '0;
    assign out_length    = out_valid ? head[OPCODE_WIDTH +: LENGTH_WIDTH] : '0;
    assign out_acc_addr  = out_valid ? head[OPCODE_WIDTH+LENGTH_WIDTH +: ACC_ADDR_WIDTH] : '0;
    assign out_buff_addr = out_valid ? head[OPCODE_WIDTH+LENGTH_WIDTH+ACC_ADDR_WIDTH +: BUFF_ADDR_WIDTH] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx   <= '0;
            asm_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            beat_idx   <= '0;
            asm_q      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                asm_q    <= asm_next;
                beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) fifo_count <= push ? fifo_count + 1'b1 : fifo_count - 1'b1;
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= asm_next;
    end
endmodule
